// File: rtl/lc3b_pc_unit.sv
// LC-3b program-counter stage: PC, condition codes, branch enable and a
// saturating taken-branch counter, all updated under control-FSM strobes.
module lc3b_pc_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter int          COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   ld_pc,
    input  logic [1:0]             pcmux_sel,
    input  logic [15:0]            br_add_out,
    input  logic [15:0]            reg_target,
    input  logic [15:0]            mem_data,
    input  logic                   ld_cc,
    input  logic [15:0]            cc_src,
    input  logic                   ld_ben,
    input  logic [2:0]             ir_nzp,
    output logic [15:0]            pc_out,
    output logic [15:0]            pc_plus2,
    output logic [2:0]             cc_out,
    output logic                   ben,
    output logic [COUNT_WIDTH-1:0] taken_count
);

    typedef enum logic [1:0] {
        SEL_PLUS2  = 2'b00,
        SEL_BRADD  = 2'b01,
        SEL_REG    = 2'b10,
        SEL_MEM    = 2'b11
    } pcmux_e;

    logic [15:0] next_pc;
    logic [2:0]  next_cc;
    logic        branch_taken;

    assign pc_plus2 = pc_out + 16'd2;

    always_comb begin
        // NOTE: default first so every path assigns next_pc; no latch.
        next_pc = pc_plus2;
        case (pcmux_e'(pcmux_sel))
            SEL_PLUS2: next_pc = pc_plus2;
            SEL_BRADD: next_pc = br_add_out;
            SEL_REG:   next_pc = reg_target;
            SEL_MEM:   next_pc = mem_data;
            default:   next_pc = pc_plus2;
        endcase
        next_pc[0] = 1'b0;
    end

    // One-hot {n,z,p}: zero takes priority only when the sign bit is clear.
    always_comb begin
        next_cc = 3'b001;
        if (cc_src[15])
            next_cc = 3'b100;
        else if (cc_src == 16'h0000)
            next_cc = 3'b010;
    end

    assign branch_taken = ld_pc && (pcmux_sel == SEL_BRADD) && ben;

    // NOTE: non-blocking assignments so every register samples pre-edge
    // values; this is what lets BEN see the old CC when ld_cc fires too.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_out      <= RESET_PC;
            cc_out      <= 3'b010;
            ben         <= 1'b0;
            taken_count <= '0;
        end else begin
            if (ld_pc)
                pc_out <= next_pc;
            if (ld_cc)
                cc_out <= next_cc;
            if (ld_ben)
                ben <= |(ir_nzp & cc_out);
            if (branch_taken && (taken_count != {COUNT_WIDTH{1'b1}}))
                taken_count <= taken_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_lc3b_pc_unit.sv
// Directed bench for lc3b_pc_unit; a COUNT_WIDTH=4 copy shares the stimulus
// so counter saturation is reachable in a few cycles.
module tb_lc3b_pc_unit;

    logic        clk;
    logic        reset_n;
    logic        ld_pc;
    logic [1:0]  pcmux_sel;
    logic [15:0] br_add_out;
    logic [15:0] reg_target;
    logic [15:0] mem_data;
    logic        ld_cc;
    logic [15:0] cc_src;
    logic        ld_ben;
    logic [2:0]  ir_nzp;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2;
    logic [2:0]  cc_out;
    logic        ben;
    logic [15:0] taken_count;

    logic [15:0] pc_out4;
    logic [15:0] pc_plus2_4;
    logic [2:0]  cc_out4;
    logic        ben4;
    logic [3:0]  taken_count4;

    int tests_run = 0;
    int tests_failed = 0;

    lc3b_pc_unit #(.RESET_PC(16'h0000), .COUNT_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .ld_pc(ld_pc), .pcmux_sel(pcmux_sel),
        .br_add_out(br_add_out), .reg_target(reg_target), .mem_data(mem_data),
        .ld_cc(ld_cc), .cc_src(cc_src), .ld_ben(ld_ben), .ir_nzp(ir_nzp),
        .pc_out(pc_out), .pc_plus2(pc_plus2), .cc_out(cc_out), .ben(ben),
        .taken_count(taken_count)
    );

    lc3b_pc_unit #(.RESET_PC(16'h0000), .COUNT_WIDTH(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .ld_pc(ld_pc), .pcmux_sel(pcmux_sel),
        .br_add_out(br_add_out), .reg_target(reg_target), .mem_data(mem_data),
        .ld_cc(ld_cc), .cc_src(cc_src), .ld_ben(ld_ben), .ir_nzp(ir_nzp),
        .pc_out(pc_out4), .pc_plus2(pc_plus2_4), .cc_out(cc_out4), .ben(ben4),
        .taken_count(taken_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        ld_pc  = 1'b0;
        ld_cc  = 1'b0;
        ld_ben = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        clear_strobes();
        pcmux_sel  = 2'b00;
        br_add_out = 16'h0000;
        reg_target = 16'h0000;
        mem_data   = 16'h0000;
        cc_src     = 16'h0000;
        ir_nzp     = 3'b000;

        #13 reset_n = 1'b1;
        #1;
        check("rst_pc",    32'(pc_out),      32'h0000);
        check("rst_plus2", 32'(pc_plus2),    32'h0002);
        check("rst_cc",    32'(cc_out),      32'h2);
        check("rst_ben",   32'(ben),         32'h0);
        check("rst_cnt",   32'(taken_count), 32'h0);

        // Sequential fetch
        ld_pc = 1'b1; pcmux_sel = 2'b00;
        for (int i = 1; i <= 3; i++) begin
            step();
            check($sformatf("fetch%0d", i), 32'(pc_out), 32'(2 * i));
        end
        check("fetch_plus2", 32'(pc_plus2), 32'h0008);

        // Wrap through FFFE
        pcmux_sel = 2'b10; reg_target = 16'hFFFE;
        step();
        check("reg_fffe",    32'(pc_out),   32'hFFFE);
        check("plus2_wrap",  32'(pc_plus2), 32'h0000);
        pcmux_sel = 2'b00;
        step();
        check("pc_wrap",     32'(pc_out),   32'h0000);
        ld_pc = 1'b0;
        step();
        check("pc_hold",     32'(pc_out),   32'h0000);

        // Condition codes
        ld_cc = 1'b1;
        cc_src = 16'h8000; step(); check("cc_8000", 32'(cc_out), 32'h4);
        cc_src = 16'h0000; step(); check("cc_0000", 32'(cc_out), 32'h2);
        cc_src = 16'h7FFF; step(); check("cc_7fff", 32'(cc_out), 32'h1);
        cc_src = 16'hFFFF; step(); check("cc_ffff", 32'(cc_out), 32'h4);
        cc_src = 16'h7FFF; step(); check("cc_back", 32'(cc_out), 32'h1);
        ld_cc = 1'b0;
        cc_src = 16'h0000; step(); check("cc_hold", 32'(cc_out), 32'h1);

        // Branch taken
        ld_ben = 1'b1; ir_nzp = 3'b001;
        step(); check("ben_p", 32'(ben), 32'h1);
        ld_ben = 1'b0; ld_pc = 1'b1; pcmux_sel = 2'b01; br_add_out = 16'h3040;
        step();
        check("br_pc",   32'(pc_out),       32'h3040);
        check("br_cnt",  32'(taken_count),  32'h1);
        check("br_cnt4", 32'(taken_count4), 32'h1);
        ld_pc = 1'b0;

        // Branch not taken still loads PC
        ld_ben = 1'b1; ir_nzp = 3'b110;
        step(); check("ben_nz", 32'(ben), 32'h0);
        ld_ben = 1'b0; ld_pc = 1'b1; br_add_out = 16'h4000;
        step();
        check("nt_pc",  32'(pc_out),      32'h4000);
        check("nt_cnt", 32'(taken_count), 32'h1);
        ld_pc = 1'b0;

        ld_ben = 1'b1;
        ir_nzp = 3'b000; step(); check("ben_000", 32'(ben), 32'h0);
        ir_nzp = 3'b111; step(); check("ben_111", 32'(ben), 32'h1);
        ld_ben = 1'b0;

        // Simultaneous ld_cc/ld_ben: BEN uses old Z
        ld_cc = 1'b1; cc_src = 16'h0000;
        step(); check("cc_z", 32'(cc_out), 32'h2);
        ld_ben = 1'b1; ir_nzp = 3'b010; cc_src = 16'h0005;
        step();
        check("sim_ben", 32'(ben),    32'h1);
        check("sim_cc",  32'(cc_out), 32'h1);
        clear_strobes();

        // Alignment; sel=11 with ben=1 is not a counted branch
        ld_pc = 1'b1; pcmux_sel = 2'b11; mem_data = 16'h1235;
        step();
        check("mem_align", 32'(pc_out),      32'h1234);
        check("mem_nocnt", 32'(taken_count), 32'h1);
        pcmux_sel = 2'b10; reg_target = 16'h0101;
        step();
        check("reg_align", 32'(pc_out), 32'h0100);

        // Saturation: ben stays 1, 19 taken branches
        pcmux_sel = 2'b01; br_add_out = 16'h0200;
        for (int i = 0; i < 14; i++) step();
        check("sat_reach4", 32'(taken_count4), 32'hF);
        for (int i = 0; i < 5; i++) step();
        check("sat_hold4",  32'(taken_count4), 32'hF);
        check("cnt16_20",   32'(taken_count),  32'd20);
        check("sat_pc",     32'(pc_out),       32'h0200);
        ld_pc = 1'b0;

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("arst_pc",   32'(pc_out),       32'h0000);
        check("arst_cc",   32'(cc_out),       32'h2);
        check("arst_ben",  32'(ben),          32'h0);
        check("arst_cnt",  32'(taken_count),  32'h0);
        check("arst_cnt4", 32'(taken_count4), 32'h0);
        #3 reset_n = 1'b1;
        step();
        check("post_rst_pc", 32'(pc_out), 32'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lc3b_pc_unit.md
Name: lc3b_pc_unit

Overview:
- Program-counter stage that consumes the branch target adder output (br_add_out) and owns the PC, condition-code (CC) and branch-enable (BEN) registers of the LC-3b datapath.
- Selects and latches the next PC under control-FSM load strobes.
- Generates pc_plus2 and drives pc_out back into the branch target adder.
- Keeps a saturating count of taken branches for performance visibility.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset; bit 0 must be 0.
- COUNT_WIDTH, 16, width of the taken-branch counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ld_pc  input  1  load PC with the selected next-PC value.
- pcmux_sel  input  2  next-PC select: 00 = pc_plus2, 01 = br_add_out, 10 = reg_target, 11 = mem_data.
- br_add_out  input  16  branch target from the branch target adder.
- reg_target  input  16  base register value (JMP/RET/JSRR).
- mem_data  input  16  memory word (trap vector fetch).
- ld_cc  input  1  update CC from cc_src.
- cc_src  input  16  value being written to the register file.
- ld_ben  input  1  latch branch enable.
- ir_nzp  input  3  IR[11:9] condition mask.
- pc_out  output  16  current PC.
- pc_plus2  output  16  pc_out + 2, combinational.
- cc_out  output  3  {n,z,p}.
- ben  output  1  registered branch enable.
- taken_count  output  COUNT_WIDTH  saturating count of taken branches.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (reset_n).
- Reset is asserted immediately and overrides all strobes; it applies mid-operation too:
  - pc_out = RESET_PC
  - cc_out = 3'b010 (Z)
  - ben = 0
  - taken_count = 0
- pc_plus2:
  - pc_out + 16'd2, modulo 2^16; 16'hFFFE -> 16'h0000.
  - Zero latency; valid in the same cycle pc_out changes.
- PC register:
  - On a clk edge with ld_pc=1, PC <= mux(pcmux_sel) with bit 0 forced to 0 (word alignment; an odd reg_target or mem_data is truncated).
  - ld_pc=0 holds PC.
  - Latency is 1 cycle from strobe to pc_out.
- CC register:
  - On ld_cc=1: n = cc_src[15]; z = (cc_src == 0); p = otherwise.
  - Exactly one bit set at all times; never 000 or multi-hot.
- BEN register:
  - On ld_ben=1: ben <= |(ir_nzp & cc_out), using the CC value registered before this edge.
  - When ld_cc and ld_ben are asserted in the same cycle, BEN sees the old CC.
  - ir_nzp = 000 gives ben = 0; ir_nzp = 111 gives ben = 1.
- Taken counter:
  - Increments on an edge where ld_pc=1, pcmux_sel=01 and ben=1, using the registered ben.
  - Saturates at all-ones with no wrap.
  - A branch load with ben=0 still loads PC, since the FSM decides; it is not counted.
- All loads are independent; any combination of strobes can occur in the same cycle.
- Unknown or X strobes are not required to be handled.

Test Plan:
- Reset: release reset_n, no strobes -> pc_out=0000, pc_plus2=0002, cc_out=010, ben=0, taken_count=0. Assert reset_n=0 mid-cycle after loads -> all outputs return to reset values without waiting for a clk edge.
- Sequential fetch and wrap:
  - ld_pc=1, sel=00 for 3 cycles from 0000 -> pc_out = 0002, 0004, 0006.
  - Load reg_target=FFFE (sel=10), then sel=00 -> pc_out=0000.
- CC generation: ld_cc with cc_src=8000 -> 100; 0000 -> 010; 7FFF -> 001; FFFF -> 100.
- Branch taken:
  - CC=001, ir_nzp=001, ld_ben -> ben=1.
  - Next cycle ld_pc, sel=01, br_add_out=3040 -> pc_out=3040, taken_count=1.
  - With ir_nzp=110 -> ben=0; the branch load still sets pc_out, but taken_count is unchanged.
- Simultaneous update: CC=010, same cycle ld_cc (cc_src=0005) and ld_ben with ir_nzp=010 -> ben=1 (old Z), cc_out=001.
- Alignment and saturation:
  - sel=11, mem_data=1235 -> pc_out=1234.
  - Preload by driving 2^COUNT_WIDTH+3 taken branches (use COUNT_WIDTH=4 build) -> taken_count holds at F.
